// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the chip-side I/O controller:
//   - state_e      : controller state encoding
//   - HDR_*_LSB    : bit positions of T and N inside the header beat
//   - CMD_LOAD/PROC: values of the feeder's cmd line
//   - elem_count   : N*T, computed 10 bits wide
//   - make_header  : builds the 32-bit header beat from N and T
// -----------------------------------------------------------------------------
package io_pkg;

  typedef enum logic [2:0] {
    LOAD,
    RUN,
    TURN,
    HDR,
    WORD,
    SEP,
    CLOSE,
    FINISH
  } state_e;

  localparam int HDR_T_LSB = 0;
  localparam int HDR_N_LSB = 4;

  localparam logic CMD_LOAD = 1'b1;
  localparam logic CMD_PROC = 1'b0;

  function automatic logic [9:0] elem_count(input logic [5:0] n, input logic [3:0] t);
    return 10'(n) * 10'(t);
  endfunction

  function automatic logic [31:0] make_header(input logic [5:0] n, input logic [3:0] t);
    logic [31:0] h;
    h = '0;
    h[HDR_N_LSB +: 6] = n;
    h[HDR_T_LSB +: 4] = t;
    return h;
  endfunction

endpackage

// File: rtl/io_controller_if.sv
// -----------------------------------------------------------------------------
// io_controller_if
// Feeder link handshake between the IO feeder (master) and the chip-side
// controller (slave). The 32-bit shared data bus stays a plain inout port on
// the controller; data_oe is exported here so the feeder side can see which
// end currently owns the bus.
//   intrpt  : feeder command strobe            (master -> slave)
//   cmd     : 1 = load, 0 = process            (master -> slave)
//   done    : packet-accepted / result beat    (slave -> master)
//   data_oe : controller is driving the bus    (slave -> master)
// -----------------------------------------------------------------------------
interface io_controller_if;

  logic intrpt;
  logic cmd;
  logic done;
  logic data_oe;

  modport master (
    output intrpt,
    output cmd,
    input  done,
    input  data_oe
  );

  modport slave (
    input  intrpt,
    input  cmd,
    output done,
    output data_oe
  );

endinterface

// File: rtl/io_tx_sequencer.sv
// -----------------------------------------------------------------------------
// io_tx_sequencer
// Row/column bookkeeping for the result stream and result-memory addressing.
//   clk, reset : clock, synchronous active-low reset
//   state      : current controller state
//   n, t       : latched N (row length) and T (row count)
//   empty      : N*T == 0, header is followed directly by the close beat
//   row_end    : the WORD beat on the bus is the last element of its row
//   last_elem  : the WORD beat on the bus is the final element overall
//   res_addr   : result-memory read address (memory has 1-cycle read latency)
// -----------------------------------------------------------------------------
module io_tx_sequencer
  import io_pkg::*;
#(
  parameter int RAW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  state_e         state,
  input  logic [5:0]     n,
  input  logic [3:0]     t,
  output logic           empty,
  output logic           row_end,
  output logic           last_elem,
  output logic [RAW-1:0] res_addr
);

  logic [5:0]     col_q, col_d;
  logic [3:0]     row_q, row_d;
  logic [RAW-1:0] addr_q, addr_d;

  assign empty     = (elem_count(n, t) == 10'd0);
  assign row_end   = (col_q == n - 6'd1);
  assign last_elem = row_end && (row_q == t - 4'd1);
  assign res_addr  = addr_q;

  // The address runs one element ahead of the bus: it advances on every
  // transition into WORD, so it holds still across the last element of a
  // row and steps again when SEP hands back to WORD.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    case (state)
      HDR: begin
        if (!empty) begin
          addr_d = addr_q + RAW'(1);
        end
      end
      WORD: begin
        if (row_end) begin
          col_d = '0;
          row_d = row_q + 4'd1;
        end else begin
          col_d  = col_q + 6'd1;
          addr_d = addr_q + RAW'(1);
        end
      end
      SEP: begin
        addr_d = addr_q + RAW'(1);
      end
      default: begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/io_controller.sv
// -----------------------------------------------------------------------------
// io_controller
// Chip-side I/O stage behind the IO feeder. Loads words into the input
// memory, starts the solver on a process command, then streams the header
// and T*N result words (with row separators and a close beat) back over
// the shared bus.
//   clk, reset  : clock, synchronous active-low reset
//   link        : feeder handshake (intrpt, cmd, done, data_oe)
//   data        : shared 32-bit bus, driven only while data_oe is high
//   mem_*       : input-memory write port
//   overflow    : sticky, a load word arrived past the memory depth
//   start       : one-cycle solver start pulse
//   solver_done : solver finished
//   n_in, t_in  : N and T, latched on the process command
//   res_addr    : result-memory read address
//   res_rdata   : result-memory read data (one cycle after res_addr)
// -----------------------------------------------------------------------------
module io_controller
  import io_pkg::*;
#(
  parameter int AW  = 10,
  parameter int RAW = 10
) (
  input  logic           clk,
  input  logic           reset,
  io_controller_if.slave link,
  inout  wire  [31:0]    data,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [31:0]    mem_wdata,
  output logic           overflow,
  output logic           start,
  input  logic           solver_done,
  input  logic [5:0]     n_in,
  input  logic [3:0]     t_in,
  output logic [RAW-1:0] res_addr,
  input  logic [31:0]    res_rdata
);

  localparam int WCW = AW + 1;

  state_e         state_q, state_d;
  logic           done_q, done_d;
  logic           start_q, start_d;
  logic           data_oe_q, data_oe_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           overflow_q, overflow_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [5:0]     n_q, n_d;
  logic [3:0]     t_q, t_d;
  logic [31:0]    data_out;

  logic seq_empty;
  logic seq_row_end;
  logic seq_last;

  io_tx_sequencer #(.RAW(RAW)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .state     (state_q),
    .n         (n_q),
    .t         (t_q),
    .empty     (seq_empty),
    .row_end   (seq_row_end),
    .last_elem (seq_last),
    .res_addr  (res_addr)
  );

  // Next-state and next-output logic. A load is only taken while done is
  // low so a strobe still high during the acknowledge cycle is not taken
  // twice. The write counter is one bit wider than the address so "full"
  // is simply its top bit.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    start_d     = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    overflow_d  = overflow_q;
    wr_cnt_d    = wr_cnt_q;
    n_d         = n_q;
    t_d         = t_q;

    case (state_q)
      LOAD: begin
        if (link.intrpt) begin
          if (link.cmd == CMD_LOAD) begin
            if (!done_q) begin
              done_d = 1'b1;
              if (!wr_cnt_q[AW]) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_cnt_q[AW-1:0];
                mem_wdata_d = data;
                wr_cnt_d    = wr_cnt_q + WCW'(1);
              end else begin
                overflow_d = 1'b1;
              end
            end
          end else if (link.cmd == CMD_PROC) begin
            start_d = 1'b1;
            n_d     = n_in;
            t_d     = t_in;
            state_d = RUN;
          end
        end
      end
      RUN:    if (solver_done) state_d = TURN;
      TURN:   state_d = HDR;
      HDR:    state_d = seq_empty ? CLOSE : WORD;
      WORD: begin
        if (seq_last) begin
          state_d = CLOSE;
        end else if (seq_row_end) begin
          state_d = SEP;
        end
      end
      SEP:    state_d = WORD;
      CLOSE:  state_d = FINISH;
      FINISH: state_d = FINISH;
      default: state_d = LOAD;
    endcase

    done_d    = done_d | (state_d inside {HDR, WORD, SEP, CLOSE});
    data_oe_d = state_d inside {TURN, HDR, WORD, SEP, CLOSE};
  end

  // Bus content follows the registered state; WORD passes the result
  // memory straight through since its read data is already registered.
  always_comb begin
    data_out = '0;
    case (state_q)
      HDR:     data_out = make_header(n_q, t_q);
      WORD:    data_out = res_rdata;
      default: data_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LOAD;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      data_oe_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overflow_q  <= 1'b0;
      wr_cnt_q    <= '0;
      n_q         <= '0;
      t_q         <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      start_q     <= start_d;
      data_oe_q   <= data_oe_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
      wr_cnt_q    <= wr_cnt_d;
      n_q         <= n_d;
      t_q         <= t_d;
    end
  end

  assign data         = data_oe_q ? data_out : 'z;
  assign link.done    = done_q;
  assign link.data_oe = data_oe_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign overflow     = overflow_q;
  assign start        = start_q;

endmodule
